// File: rtl/led_pattern_gen.sv
// led_pattern_gen: shared tick prescaler driving CHANNELS independent off/on/blink/one-shot LED outputs.
// Optional feature macro: LED_PWM_DIM_EN adds per-channel 8-bit PWM dimming of the on-phase.

module led_chan (
  input  logic        in_clk,
  input  logic        reset,
  input  logic        i_tick,
  input  logic        i_wr,
  input  logic [1:0]  i_mode,
  input  logic [15:0] i_half,
  output logic        o_st
);
  logic [1:0]  r_mode;
  logic [15:0] r_half;
  logic [15:0] r_ph;
  logic        r_st;
  logic [15:0] w_len;
  logic        w_wrap;

  assign w_len  = (r_half == 16'd0) ? 16'd1 : r_half;
  // 17-bit compare so ph+1 cannot overflow when half = 0xFFFF
  assign w_wrap = ({1'b0, r_ph} + 17'd1) >= {1'b0, w_len};

  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      r_mode <= 2'd0;
      r_half <= 16'd0;
      r_ph   <= 16'd0;
      r_st   <= 1'b0;
    end else if (i_wr) begin
      r_mode <= i_mode;
      r_half <= i_half;
      r_ph   <= 16'd0;
      r_st   <= (i_mode != 2'd0);
    end else if (i_tick && r_mode[1]) begin
      if (w_wrap) begin
        r_ph <= 16'd0;
        if (r_mode == 2'd2) begin
          r_st <= ~r_st;
        end else begin
          r_mode <= 2'd0;
          r_st   <= 1'b0;
        end
      end else begin
        r_ph <= r_ph + 16'd1;
      end
    end
  end

  assign o_st = r_st;
endmodule

module led_pattern_gen #(
  parameter  int OSC_CLOCK = 27000000,
  parameter  int TICK_HZ   = 1000,
  parameter  int CHANNELS  = 4,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                in_clk,
  input  logic                reset,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [15:0]         cfg_half,
  input  logic [7:0]          cfg_bright,
  output logic                tick,
  output logic [CHANNELS-1:0] led
);
  localparam int DIV = OSC_CLOCK / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  logic [PW-1:0]       r_pre;
  logic [CHANNELS-1:0] w_wr;
  logic [CHANNELS-1:0] w_st;
  logic [CHANNELS-1:0] w_on;

  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (r_pre == PW'(DIV - 1));
      r_pre <= (r_pre == PW'(DIV - 1)) ? '0 : r_pre + 1'b1;
    end
  end

  // Out-of-range channel numbers match no decode line and are dropped
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_wr[g] = cfg_wr && (cfg_chan == CH_W'(g));
    led_chan u_chan (
      .in_clk (in_clk),
      .reset  (reset),
      .i_tick (tick),
      .i_wr   (w_wr[g]),
      .i_mode (cfg_mode),
      .i_half (cfg_half),
      .o_st   (w_st[g])
    );
  end

`ifdef LED_PWM_DIM_EN
  logic [7:0]                r_pwm;
  logic [CHANNELS-1:0][7:0]  r_bright;

  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      r_pwm    <= 8'd0;
      r_bright <= '0;
    end else begin
      r_pwm <= r_pwm + 8'd1;
      for (int i = 0; i < CHANNELS; i++)
        if (w_wr[i]) r_bright[i] <= cfg_bright;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pwm
    assign w_on[g] = w_st[g] && (r_pwm < r_bright[g]);
  end
`else
  logic w_unused_bright;
  assign w_unused_bright = ^cfg_bright;
  assign w_on = w_st;
`endif

  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) led <= '0;
    else       led <= w_on;
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: constant-expectation table, directed multi-cycle sequences and a random
// phase, all cross-checked every cycle against a tick-counting behavioural model.

module tb_led_pattern_gen;
  localparam int DIV = 10;

  logic        in_clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_chan = 2'd0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [15:0] cfg_half = 16'd0;
  logic [7:0]  cfg_bright = 8'd0;
  logic        tick, tick3;
  logic [3:0]  led;
  logic [2:0]  led3;

  always #5 in_clk = ~in_clk;

  led_pattern_gen #(.OSC_CLOCK(100), .TICK_HZ(10), .CHANNELS(4)) dut (
    .in_clk(in_clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_chan(cfg_chan), .cfg_mode(cfg_mode),
    .cfg_half(cfg_half), .cfg_bright(cfg_bright), .tick(tick), .led(led));

  led_pattern_gen #(.OSC_CLOCK(100), .TICK_HZ(10), .CHANNELS(3)) dut3 (
    .in_clk(in_clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_chan(cfg_chan), .cfg_mode(cfg_mode),
    .cfg_half(cfg_half), .cfg_bright(cfg_bright), .tick(tick3), .led(led3));

  typedef struct {
    logic [1:0]  chan;
    logic [1:0]  mode;
    logic [15:0] half;
    logic [3:0]  exp_led;
  } vec_t;

  vec_t vecs[8];
  int n_chk = 0;
  int n_fail = 0;

  // Model: per channel, ticks elapsed since the last write; state follows from arithmetic on that count
  int         m_edges;
  int         m_mode[4], m_h[4], m_k[4], m_bright[4];
  logic [3:0] m_st, m_led;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    for (int i = 0; i < 4; i++) begin
      m_mode[i] = 0; m_h[i] = 1; m_k[i] = 0; m_bright[i] = 0;
    end
    m_st = '0;
    m_led = '0;
  endtask

  task automatic model_edge();
    logic t_in;
    t_in = (m_edges > 0) && (m_edges % DIV == 0);
    for (int i = 0; i < 4; i++) begin
`ifdef LED_PWM_DIM_EN
      m_led[i] = m_st[i] && ((m_edges % 256) < m_bright[i]);
`else
      m_led[i] = m_st[i];
`endif
    end
    for (int i = 0; i < 4; i++) begin
      if (cfg_wr && cfg_chan == i) begin
        m_mode[i] = cfg_mode;
        m_h[i] = (cfg_half == 16'd0) ? 1 : int'(cfg_half);
        m_k[i] = 0;
        m_bright[i] = cfg_bright;
      end else if (t_in && m_mode[i] >= 2) begin
        m_k[i]++;
        if (m_mode[i] == 3 && m_k[i] >= m_h[i]) m_mode[i] = 0;
      end
      case (m_mode[i])
        0:       m_st[i] = 1'b0;
        1:       m_st[i] = 1'b1;
        2:       m_st[i] = ((m_k[i] / m_h[i]) % 2) == 0;
        default: m_st[i] = m_k[i] < m_h[i];
      endcase
    end
    m_edges++;
  endtask

  task automatic step();
    logic exp_tick;
    @(posedge in_clk);
    model_edge();
    @(negedge in_clk);
    exp_tick = (m_edges > 0) && (m_edges % DIV == 0);
    check("tick", tick, exp_tick);
    check("tick3", tick3, exp_tick);
    check("led", led, m_led);
    check("led3", led3, m_led[2:0]);
  endtask

  task automatic wr(input int ch, input int mode, input int half, input int bright);
    cfg_wr = 1'b1; cfg_chan = 2'(ch); cfg_mode = 2'(mode);
    cfg_half = 16'(half); cfg_bright = 8'(bright);
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic run_len(input int ch, input logic val, input int n0, output int n);
    n = n0;
    for (int s = 0; s < 300; s++) begin
      step();
      if (led[ch] === val) n++;
      else return;
    end
    n_chk++; n_fail++;
    $display("FAIL run_len ch%0d: led stuck at %0b beyond 300 cycles", ch, val);
  endtask

  task automatic sync_tick();
    for (int s = 0; s < 25; s++) begin
      if (tick === 1'b1) return;
      step();
    end
    n_chk++; n_fail++;
    $display("FAIL sync_tick: no tick within 25 cycles");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt;
    logic [3:0] prev;

    vecs[0] = '{2'd0, 2'd1, 16'd0, 4'b0001};
    vecs[1] = '{2'd2, 2'd1, 16'd7, 4'b0101};
    vecs[2] = '{2'd3, 2'd1, 16'd0, 4'b1101};
    vecs[3] = '{2'd0, 2'd0, 16'd3, 4'b1100};
    vecs[4] = '{2'd1, 2'd1, 16'd5, 4'b1110};
    vecs[5] = '{2'd3, 2'd0, 16'd0, 4'b0110};
    vecs[6] = '{2'd2, 2'd0, 16'd1, 4'b0010};
    vecs[7] = '{2'd1, 2'd0, 16'd0, 4'b0000};

    model_reset();
    repeat (3) @(negedge in_clk);
    check("rst_led", led, 4'b0000);
    check("rst_tick", tick, 1'b0);
    reset = 1'b0;

    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 9)  check("tick_pre_first", tick, 1'b0);
      if (c == 10) check("tick_first", tick, 1'b1);
      if (c == 20) check("tick_second", tick, 1'b1);
    end

    prev = 4'b0000;
    for (int v = 0; v < 8; v++) begin
      wr(vecs[v].chan, vecs[v].mode, vecs[v].half, 0);
      check("tbl_latency", led, prev);
      step();
      check("tbl_led", led, vecs[v].exp_led);
      prev = vecs[v].exp_led;
    end

    // Writes land on tick-sampling edges: the coincident tick must not be counted
    sync_tick();
    wr(1, 2, 3, 0);
    run_len(1, 1'b1, 0, n);
    check("blink_hi_len", n, 30);
    run_len(1, 1'b0, 1, n);
    check("blink_lo_len", n, 30);
    wr(1, 0, 0, 0);

    sync_tick();
    wr(2, 3, 2, 0);
    run_len(2, 1'b1, 0, n);
    check("oneshot_len", n, 20);
    repeat (25) step();
    check("oneshot_stays_off", led[2], 1'b0);

    sync_tick();
    wr(2, 3, 2, 0);
    repeat (14) step();
    wr(2, 3, 2, 0);
    run_len(2, 1'b1, 15, n);
    check("oneshot_rewrite_len", n, 30);

    sync_tick();
    wr(0, 2, 0, 0);
    run_len(0, 1'b1, 0, n);
    check("half0_hi_len", n, 10);
    run_len(0, 1'b0, 1, n);
    check("half0_lo_len", n, 10);
    wr(0, 0, 0, 0);
    step();

    wr(3, 1, 5, 0);
    step();
    check("ch3_on", led[3], 1'b1);
    check("ch3_ignored_3ch", led3, 3'b000);
    wr(3, 0, 0, 0);

    wr(1, 2, 1, 0);
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    check("async_rst_led", led, 4'b0000);
    check("async_rst_tick", tick, 1'b0);
    model_reset();
    @(negedge in_clk);
    reset = 1'b0;

    for (int r = 0; r < 1500; r++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_wr = 1'b1;
        cfg_chan = 2'($urandom_range(0, 3));
        cfg_mode = 2'($urandom_range(0, 3));
        cfg_half = 16'($urandom_range(0, 4));
        cfg_bright = 8'($urandom);
      end
      step();
      cfg_wr = 1'b0;
    end

    wr(3, 2, 16'hFFFF, 255);
    repeat (60) step();
    wr(2, 3, 16'hFFFF, 255);
    repeat (60) step();
    check("half_max_blink", m_st[3], 1'b1);
    check("half_max_oneshot", m_st[2], 1'b1);

`ifdef LED_PWM_DIM_EN
    for (int c = 0; c < 4; c++) wr(c, 0, 0, 0);
    wr(3, 1, 0, 64);
    repeat (2) step();
    cnt = 0;
    for (int s = 0; s < 256; s++) begin
      step();
      if (led[3]) cnt++;
    end
    check("pwm_bright64", cnt, 64);
    wr(3, 1, 0, 0);
    repeat (2) step();
    cnt = 0;
    for (int s = 0; s < 256; s++) begin
      step();
      if (led[3]) cnt++;
    end
    check("pwm_bright0", cnt, 0);
`else
    cnt = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
